// File: rtl/alu_op_scheduler.sv
`default_nettype none
//============================================================================
// alu_op_scheduler: round-robin issue of two requesters' operations onto the
// shared ALU unit bank; waits the unit latency and returns the tagged result.
// Rev 1.0
//============================================================================
module alu_op_scheduler #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [DATA_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] B0,
  input  logic [DATA_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] B1,
  input  logic [3:0]            FUN0,
  input  logic [3:0]            FUN1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [1:0]            ALU_FUN,
  output logic                  Arith_Enable,
  output logic                  Logic_Enable,
  output logic                  CMP_Enable,
  output logic                  SHIFT_Enable,
  input  logic [OUT_WIDTH-1:0]  ALU_RESULT,
  input  logic                  ALU_FLAG,
  output logic [OUT_WIDTH-1:0]  RESULT,
  output logic                  RESULT_FLAG,
  output logic                  RESULT_VALID,
  output logic                  RESULT_ID,
  output logic                  BUSY
);

  localparam logic [2:0] c_alu_latency = 3'(ALU_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_last_id;
  logic       r_owner;

  logic       w_win;
  logic [3:0] w_fun;

  // A lone request always wins; on a tie the requester not served last wins.
  assign w_win = REQ1 & (~REQ0 | ~r_last_id);
  assign w_fun = w_win ? FUN1 : FUN0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_last_id    <= 1'b1;
      r_owner      <= 1'b0;
      GNT0         <= 1'b0;
      GNT1         <= 1'b0;
      ALU_A        <= '0;
      ALU_B        <= '0;
      ALU_FUN      <= 2'b00;
      Arith_Enable <= 1'b0;
      Logic_Enable <= 1'b0;
      CMP_Enable   <= 1'b0;
      SHIFT_Enable <= 1'b0;
      RESULT       <= '0;
      RESULT_FLAG  <= 1'b0;
      RESULT_VALID <= 1'b0;
      RESULT_ID    <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      GNT0         <= 1'b0;
      GNT1         <= 1'b0;
      Arith_Enable <= 1'b0;
      Logic_Enable <= 1'b0;
      CMP_Enable   <= 1'b0;
      SHIFT_Enable <= 1'b0;
      RESULT_VALID <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (REQ0 || REQ1) begin
            r_owner   <= w_win;
            r_last_id <= w_win;
            ALU_A     <= w_win ? A1 : A0;
            ALU_B     <= w_win ? B1 : B0;
            ALU_FUN   <= w_fun[1:0];
            GNT0      <= ~w_win;
            GNT1      <= w_win;
            // Grant and unit enable are registered so both appear in ISSUE.
            {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable} <= 4'b0001 << w_fun[3:2];
            BUSY      <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= c_alu_latency;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            RESULT       <= ALU_RESULT;
            RESULT_FLAG  <= ALU_FLAG;
            RESULT_VALID <= 1'b1;
            RESULT_ID    <= r_owner;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// Bench for alu_op_scheduler: two instances (latency 1 and 3), random requesters,
// a unit-bank model and a scoreboard of expected grants and results.
module tb_alu_op_scheduler;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    int          gcyc;
    int          rcyc;
  } op_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic clk      = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input int lat, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lat%0d %s: got 0x%0h expected 0x%0h at %0t", lat, nm, act, exp, $time);
    end
  endtask

  // What each unit is defined to compute for a full 4-bit function code.
  function automatic logic [32:0] unit_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    logic        fl;
    case (f[3:2])
      2'd0:    begin r = {16'h0, a} + {16'h0, b} + {30'h0, f[1:0]}; fl = r[16]; end
      2'd1:    begin r = {16'h0, (f[0] ? (a | b) : (a & b))} ^ {31'h0, f[1]}; fl = (r == 32'h0); end
      2'd2:    begin r = (a > b) ? 32'd2 : ((a == b) ? {30'h0, f[1:0]} : 32'd0); fl = (a != b); end
      default: begin r = {16'h0, a} << b[3:0]; fl = f[0]; end
    endcase
    return {fl, r};
  endfunction

  function automatic logic [35:0] rand_op(input int i, input bit fixed);
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    a = 16'($urandom);
    b = ($urandom_range(3) == 0) ? a : 16'($urandom);
    f = fixed ? ((i == 0) ? 4'b0000 : 4'b1100) : 4'($urandom);
    return {f, b, a};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic        rst;
    logic [1:0]  req;
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [3:0]  fun [2];
    logic        gnt0, gnt1, en_ar, en_lo, en_cm, en_sh;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_fun;
    logic [31:0] alu_result, result;
    logic        alu_flag, result_flag, result_valid, result_id, busy;

    alu_op_scheduler #(.DATA_WIDTH(16), .OUT_WIDTH(32), .ALU_LATENCY(LAT)) u_dut (
      .CLK(clk), .RST(rst),
      .REQ0(req[0]), .REQ1(req[1]),
      .A0(a[0]), .B0(b[0]), .A1(a[1]), .B1(b[1]),
      .FUN0(fun[0]), .FUN1(fun[1]),
      .GNT0(gnt0), .GNT1(gnt1),
      .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
      .Arith_Enable(en_ar), .Logic_Enable(en_lo), .CMP_Enable(en_cm), .SHIFT_Enable(en_sh),
      .ALU_RESULT(alu_result), .ALU_FLAG(alu_flag),
      .RESULT(result), .RESULT_FLAG(result_flag), .RESULT_VALID(result_valid),
      .RESULT_ID(result_id), .BUSY(busy)
    );

    // Unit bank: each enabled unit's output appears for one cycle, LAT edges later.
    bit        pv [0:7];
    bit [32:0] pd [0:7];
    always @(posedge clk) begin
      logic [32:0] r;
      logic [3:0]  en;
      r  = '0;
      en = {en_sh, en_cm, en_lo, en_ar};
      for (int u = 0; u < 4; u++)
        if (en[u]) r = r | unit_fn({u[1:0], alu_fun}, alu_a, alu_b);
      pv[0] <= |en;
      pd[0] <= r;
      for (int s = 1; s < 8; s++) begin
        pv[s] <= pv[s-1];
        pd[s] <= pd[s-1];
      end
    end
    assign alu_result = pv[LAT-1] ? pd[LAT-1][31:0] : 32'h0;
    assign alu_flag   = pv[LAT-1] & pd[LAT-1][32];

    op_t         sb [$];
    int          cyc      = 0;
    int          free_cyc = 0;
    int          n_res    = 0;
    logic        m_last   = 1'b1;
    logic [15:0] m_a      = '0;
    logic [15:0] m_b      = '0;
    logic [1:0]  m_fun    = '0;
    logic [31:0] m_res    = '0;
    logic        m_flag   = 1'b0;
    logic [1:0]  gs       = '0;
    bit          fin_req  = 1'b0;
    bit          done_g   = 1'b0;

    // Monitor compares the current cycle, then the model reacts to this cycle's inputs.
    always @(negedge clk) begin
      logic [1:0]  g_exp;
      logic [3:0]  e_exp;
      logic        v_exp;
      logic [32:0] r_exp;
      logic        w;
      op_t         o;
      if (!done_g) begin
        gs    = {gnt1, gnt0};
        g_exp = '0;
        e_exp = '0;
        v_exp = 1'b0;
        if (sb.size() > 0 && sb[0].gcyc == cyc) begin
          g_exp[sb[0].id]        = 1'b1;
          e_exp[sb[0].fun[3:2]]  = 1'b1;
        end
        if (sb.size() > 0 && sb[0].rcyc == cyc) v_exp = 1'b1;
        check(LAT, "busy",    64'(busy), 64'(cyc < free_cyc));
        check(LAT, "gnt",     64'({gnt1, gnt0}), 64'(g_exp));
        check(LAT, "enables", 64'({en_sh, en_cm, en_lo, en_ar}), 64'(e_exp));
        check(LAT, "alu_a",   64'(alu_a), 64'(m_a));
        check(LAT, "alu_b",   64'(alu_b), 64'(m_b));
        check(LAT, "alu_fun", 64'(alu_fun), 64'(m_fun));
        check(LAT, "valid",   64'(result_valid), 64'(v_exp));
        if (v_exp) begin
          r_exp  = unit_fn(sb[0].fun, sb[0].a, sb[0].b);
          m_res  = r_exp[31:0];
          m_flag = r_exp[32];
          check(LAT, "result_id", 64'(result_id), 64'(sb[0].id));
          void'(sb.pop_front());
          n_res++;
        end
        check(LAT, "result",      64'(result), 64'(m_res));
        check(LAT, "result_flag", 64'(result_flag), 64'(m_flag));

        if (rst) begin
          sb.delete();
          free_cyc = cyc + 1;
          m_last   = 1'b1;
          m_a      = '0;
          m_b      = '0;
          m_fun    = '0;
          m_res    = '0;
          m_flag   = 1'b0;
        end else if (cyc >= free_cyc && (req[0] || req[1])) begin
          w      = (req[0] && req[1]) ? ~m_last : req[1];
          o.id   = w;
          o.a    = a[w];
          o.b    = b[w];
          o.fun  = fun[w];
          o.gcyc = cyc + 1;
          o.rcyc = cyc + LAT + 2;
          sb.push_back(o);
          m_a      = a[w];
          m_b      = b[w];
          m_fun    = fun[w][1:0];
          m_last   = w;
          free_cyc = cyc + LAT + 3;
        end

        if (fin_req) begin
          check(LAT, "drained", 64'(sb.size()), 64'(0));
          check(LAT, "results_seen", 64'(n_res >= 10), 64'(1));
          done_g = 1'b1;
        end
        cyc++;
      end
    end

    // Requesters: hold REQ until GNT, then drop or present a new operation.
    initial begin
      int rate;
      bit keep;
      bit fixed;
      bit arm;
      rst    = 1'b1;
      req    = 2'b01;
      a[0]   = 16'd10;
      b[0]   = 16'd3;
      fun[0] = 4'b1010;
      a[1]   = '0;
      b[1]   = '0;
      fun[1] = '0;
      arm    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 460; k++) begin
        rst   = 1'b0;
        rate  = (k >= 80 && k < 420) ? 30 : 0;
        fixed = (k < 60);
        keep  = (k >= 13 && k < 13 + 4 * (LAT + 3) + 2) ||
                (k >= 80 && k < 420 && $urandom_range(1) == 1);
        if (arm && gs[0]) begin
          rst = 1'b1;
          arm = 1'b0;
        end
        if (k == 12) rst = 1'b1;
        if (k == 13) begin
          for (int i = 0; i < 2; i++) begin
            req[i] = 1'b1;
            {fun[i], b[i], a[i]} = rand_op(i, fixed);
          end
        end
        if (k == 60 || k == 70) begin
          req[0] = 1'b1;
          {fun[0], b[0], a[0]} = rand_op(0, fixed);
          arm = (k == 60);
        end
        if (k >= 80 && k < 420 && $urandom_range(199) == 0) rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
          if (req[i] && gs[i]) begin
            if (keep) {fun[i], b[i], a[i]} = rand_op(i, fixed);
            else      req[i] = 1'b0;
          end else if (!req[i] && $urandom_range(99) < rate) begin
            req[i] = 1'b1;
            {fun[i], b[i], a[i]} = rand_op(i, fixed);
          end
        end
        @(posedge clk);
        #1;
      end
      fin_req = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_lat[0].done_g && g_lat[1].done_g);
      begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: run did not complete");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
